// File: rtl/apb_timer_slave_pkg.sv
// Shared definitions for the APB timer slave: register map, CTRL field layout,
// FSM encodings and the write-strobe bundle passed from the APB front end to the core.
package apb_timer_slave_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_VALUE  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN_BIT        = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT    = 1;
  localparam int unsigned CTRL_RELOAD_BIT    = 2;
  localparam int unsigned CTRL_PRESC_LSB     = 8;
  localparam int unsigned CTRL_PRESC_W       = 8;
  localparam int unsigned STATUS_EXPIRED_BIT = 0;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  typedef struct packed {
    logic                    ctrl_we;
    logic                    load_we;
    logic                    status_we;
    logic [DATA_W-1:0]       wdata;
  } reg_wr_t;

  typedef struct packed {
    logic                    en;
    logic                    irq_en;
    logic                    reload;
    logic [CTRL_PRESC_W-1:0] prescale;
  } ctrl_t;

  // CTRL readback image; unimplemented bits read as zero.
  function automatic logic [DATA_W-1:0] ctrl_pack(input ctrl_t c);
    return DATA_W'({16'h0000, c.prescale, 5'b00000, c.reload, c.irq_en, c.en});
  endfunction

endpackage

// File: rtl/apb_timer_core.sv
// Timer datapath: prescaler, VALUE down-counter, EXPIRED flag, reload/auto-stop and irq.
module apb_timer_core
  import apb_timer_slave_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  reg_wr_t           wr_i,
  output ctrl_t             ctrl_o,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] value_o,
  output logic              expired_o,
  output logic              irq_o
);

  ctrl_t                 ctrl_q, ctrl_d;
  logic [DATA_W-1:0]     load_q, load_d;
  logic [DATA_W-1:0]     value_q, value_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  expired_q, expired_d;
  logic                  irq_q, irq_d;
  logic                  tick;
  logic                  at_zero;

  assign tick    = ctrl_q.en & (presc_q == PRESCALE_W'(ctrl_q.prescale));
  assign at_zero = (value_q == '0);

  // Later assignments carry priority: bus writes override timer updates,
  // while expiry overrides the STATUS clear.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    value_d   = value_q;
    presc_d   = presc_q;
    expired_d = expired_q;
    irq_d     = expired_q & ctrl_q.irq_en;

    if (!ctrl_q.en || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESCALE_W'(1);
    end

    if (tick) begin
      if (!at_zero) begin
        value_d = value_q - DATA_W'(1);
      end else if (ctrl_q.reload) begin
        value_d = load_q;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end

    if (wr_i.status_we && wr_i.wdata[STATUS_EXPIRED_BIT]) begin
      expired_d = 1'b0;
    end
    if (tick && at_zero) begin
      expired_d = 1'b1;
    end

    if (wr_i.load_we) begin
      load_d  = wr_i.wdata;
      value_d = wr_i.wdata;
      presc_d = '0;
    end

    if (wr_i.ctrl_we) begin
      ctrl_d.en       = wr_i.wdata[CTRL_EN_BIT];
      ctrl_d.irq_en   = wr_i.wdata[CTRL_IRQ_EN_BIT];
      ctrl_d.reload   = wr_i.wdata[CTRL_RELOAD_BIT];
      ctrl_d.prescale = wr_i.wdata[CTRL_PRESC_LSB +: CTRL_PRESC_W];
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      value_q   <= '0;
      presc_q   <= '0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
      irq_q     <= irq_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign load_o    = load_q;
  assign value_o   = value_q;
  assign expired_o = expired_q;
  assign irq_o     = irq_q;

endmodule

// File: rtl/apb_timer_slave.sv
// APB front end of the 4-register down-counting timer.
// Optional access wait states are enabled by defining APB_TIMER_WAIT_EN.
module apb_timer_slave
  import apb_timer_slave_pkg::*;
#(
`ifdef APB_TIMER_WAIT_EN
  parameter int unsigned WAIT_CYCLES = 1,
`endif
  parameter int unsigned PRESCALE_W  = 8
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq
);

  logic [0:0]        state_q, state_d;
  logic              wait_done;
  logic [1:0]        reg_sel;
  logic              acc_err;
  logic              wr_en;
  reg_wr_t           wr;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] value_val;
  logic              expired;
  logic              unused_addr_lsb;

`ifdef APB_TIMER_WAIT_EN
  localparam int unsigned WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  assign wait_done = (wcnt_q == WCNT_W'(WAIT_CYCLES));
`else
  assign wait_done = 1'b1;
`endif

  assign reg_sel         = paddr[3:2];
  assign acc_err         = (|paddr[ADDR_W-1:4]) | (pwrite & (reg_sel == REG_VALUE));
  assign unused_addr_lsb = ^paddr[1:0];

  // pready is combinational so that reset removes it immediately.
  always_comb begin
    state_d = state_q;
    pready  = 1'b0;
`ifdef APB_TIMER_WAIT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d = ST_ACCESS;
`ifdef APB_TIMER_WAIT_EN
          wcnt_d  = '0;
`endif
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (penable && wait_done) begin
          pready  = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef APB_TIMER_WAIT_EN
        else if (!wait_done) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= ST_IDLE;
`ifdef APB_TIMER_WAIT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef APB_TIMER_WAIT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign pslverr = pready & acc_err;
  assign wr_en   = pready & pwrite & ~acc_err;

  assign wr.ctrl_we   = wr_en & (reg_sel == REG_CTRL);
  assign wr.load_we   = wr_en & (reg_sel == REG_LOAD);
  assign wr.status_we = wr_en & (reg_sel == REG_STATUS);
  assign wr.wdata     = pwdata;

  apb_timer_core #(
    .PRESCALE_W (PRESCALE_W)
  ) u_core (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .wr_i      (wr),
    .ctrl_o    (ctrl),
    .load_o    (load_val),
    .value_o   (value_val),
    .expired_o (expired),
    .irq_o     (irq)
  );

  // Read data is driven only for a successful read completion.
  always_comb begin
    prdata = '0;
    if (pready && !pwrite && !acc_err) begin
      case (reg_sel)
        REG_CTRL:   prdata = ctrl_pack(ctrl);
        REG_LOAD:   prdata = load_val;
        REG_VALUE:  prdata = value_val;
        REG_STATUS: prdata = DATA_W'(expired);
        default:    prdata = '0;
      endcase
    end
  end

endmodule
